// File: rtl/product_accumulator.sv
// product_accumulator
//   Accepts 4-bit unsigned operand pairs over a valid/ready handshake,
//   multiplies them with an internal four_bit_unsigned_multiplier, registers
//   each 8-bit product and sums a group of up to N_TERMS products. The group
//   sum and term count are presented on a valid/ready output handshake.
//
//   Optional feature macro: PRODUCT_ACCUMULATOR_SATURATE_EN
//     defined   : accumulator saturates at 2^ACC_W-1 and a sticky overflow
//                 flag is presented on out_ovf_o together with the sum.
//     undefined : accumulator wraps modulo 2^ACC_W; out_ovf_o is tied low.
//
//   Handshake rule (both ports): a transfer happens on a rising clk edge
//   where valid and ready are both high; the producer holds its data stable
//   from raising valid until that edge, and valid never waits on ready.
//
//   Pipeline: accept edge loads p_reg_q; the next edge adds it into acc_q.
//   A closing accept moves ACCUM->DRAIN; the DRAIN edge adds the last product
//   and moves to DONE, where out_valid_o is high.

// Combinational 4x4 unsigned multiplier built from shifted partial products.
module four_bit_unsigned_multiplier (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] product_o
);
    logic [7:0] pp0;
    logic [7:0] pp1;
    logic [7:0] pp2;
    logic [7:0] pp3;

    // One partial product per bit of b_i, shifted by its weight.
    always_comb begin
        pp0       = b_i[0] ? {4'b0000, a_i}        : 8'd0;
        pp1       = b_i[1] ? {3'b000,  a_i, 1'b0}  : 8'd0;
        pp2       = b_i[2] ? {2'b00,   a_i, 2'b00} : 8'd0;
        pp3       = b_i[3] ? {1'b0,    a_i, 3'b000} : 8'd0;
        product_o = pp0 + pp1 + pp2 + pp3;
    end
endmodule

module product_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12,
    parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       in_a_i,
    input  logic [3:0]       in_b_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_sum_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_ovf_o,
    output logic [1:0]       dbg_state_o
);
    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [7:0]       p_reg_q;
    logic [7:0]       p_reg_d;
    logic             p_vld_q;
    logic             p_vld_d;

    logic [7:0]       product;
    logic             accept;
    logic             close_group;
    logic             out_hs;
    logic [CNT_W-1:0] count_inc;
    logic [ACC_W-1:0] acc_add;

    four_bit_unsigned_multiplier u_mult (
        .a_i       (in_a_i),
        .b_i       (in_b_i),
        .product_o (product)
    );

    // Ready only while collecting terms and never while reset is held.
    always_comb begin
        in_ready_o  = rst_ni && (state_q == ST_ACCUM);
        accept      = in_valid_i && in_ready_o;
        count_inc   = count_q + 1'b1;
        close_group = accept && (in_last_i || (count_inc == CNT_W'(N_TERMS)));
        out_hs      = (state_q == ST_DONE) && out_ready_i;
    end

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    logic             ovf_q;
    logic             ovf_d;
    logic [ACC_W:0]   sum_wide;
    logic             ovf_set;

    // Add with one carry bit; a carry means the true sum no longer fits.
    always_comb begin
        sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(p_reg_q);
        ovf_set  = sum_wide[ACC_W];
        acc_add  = ovf_set ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    end

    // Sticky overflow flag, cleared when the sum is handed off.
    always_comb begin
        ovf_d = ovf_q;
        if (p_vld_q) begin
            ovf_d = ovf_q | ovf_set;
        end
        if (out_hs) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf_o = ovf_q;
`else
    // Plain modulo-2^ACC_W accumulation.
    always_comb begin
        acc_add = acc_q + ACC_W'(p_reg_q);
    end

    assign out_ovf_o = 1'b0;
`endif

    // Next-state logic for the product stage, accumulator, counter and FSM.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        p_reg_d = p_reg_q;
        p_vld_d = p_vld_q;

        // Fold the registered product in; a same-cycle accept refills below.
        if (p_vld_q) begin
            acc_d   = acc_add;
            p_vld_d = 1'b0;
        end

        if (accept) begin
            p_reg_d = product;
            p_vld_d = 1'b1;
            count_d = count_inc;
        end

        case (state_q)
            ST_ACCUM: begin
                if (close_group) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The final product is added on this edge.
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_hs) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any group.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            p_reg_q <= '0;
            p_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            p_reg_q <= p_reg_d;
            p_vld_q <= p_vld_d;
        end
    end

    // The accumulator and counter are frozen in DONE, so they drive the outputs directly.
    always_comb begin
        out_valid_o = (state_q == ST_DONE);
        out_sum_o   = acc_q;
        out_count_o = count_q;
        dbg_state_o = state_q;
    end
endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;
  localparam int N_TERMS = 4;
  localparam int ACC_W = 12;
  localparam int CNT_W = $clog2(N_TERMS + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic in_valid;
  logic in_last;
  logic out_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic in_ready;
  logic out_valid;
  logic out_ovf;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic [1:0] dbg_state;

  logic in_valid8;
  logic in_ready8;
  logic out_valid8;
  logic out_ovf8;
  logic [7:0] out_sum8;
  logic [1:0] out_count8;
  logic [1:0] dbg_state8;

  product_accumulator #(.N_TERMS(N_TERMS), .ACC_W(ACC_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_sum_o(out_sum), .out_count_o(out_count),
    .out_ovf_o(out_ovf), .dbg_state_o(dbg_state)
  );

  product_accumulator #(.N_TERMS(2), .ACC_W(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last), .out_valid_o(out_valid8),
    .out_ready_i(out_ready), .out_sum_o(out_sum8), .out_count_o(out_count8),
    .out_ovf_o(out_ovf8), .dbg_state_o(dbg_state8)
  );

  // ---------------- scoreboard ----------------
  logic [ACC_W-1:0] exp_q[$];
  logic [CNT_W-1:0] cnt_q[$];
  int acc_m = 0;
  int cnt_m = 0;
  int checks = 0;
  int passed = 0;
  int hs_cnt = 0;
  int acc_cnt = 0;

  always @(posedge clk) begin
    if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last);
    int guard;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    acc_m += int'(a) * int'(b);
    cnt_m++;
    if (last || cnt_m == N_TERMS) begin
      exp_q.push_back(ACC_W'(acc_m));
      cnt_q.push_back(CNT_W'(cnt_m));
      acc_m = 0;
      cnt_m = 0;
    end
  endtask

  task automatic wait_out(output bit ok);
    int guard;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ok = out_valid;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_valid8 = 1'b0; in_a = 4'd3; in_b = 4'd3;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else passed++;
    checks++; if (out_sum !== '0) $display("FAIL reset_out_sum: got %0d required 0", out_sum); else passed++;
    checks++; if (out_count !== '0) $display("FAIL reset_out_count: got %0d required 0", out_count); else passed++;
    checks++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b required 0", out_ovf); else passed++;
    checks++; if (in_ready8 !== 1'b0) $display("FAIL reset_in_ready8: got %b required 0", in_ready8); else passed++;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b required 1", in_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [ACC_W-1:0] es;
    logic [CNT_W-1:0] ec;
    int hs0;
    out_ready = 1'b1;
    hs0 = hs_cnt;
    send(4'd3, 4'd5, 1'b0);
    send(4'd15, 4'd15, 1'b0);
    send(4'd0, 4'd9, 1'b0);
    send(4'd2, 4'd7, 1'b0);
    // one cycle after the closing accept edge: draining
    checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain_valid: got %b required 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL b2b_drain_ready: got %b required 0", in_ready); else passed++;
    checks++; if (dbg_state !== 2'd1) $display("FAIL b2b_drain_state: got %0d required 1", dbg_state); else passed++;
    @(posedge clk); #1;
    es = exp_q.pop_front();
    ec = cnt_q.pop_front();
    checks++; if (out_valid !== 1'b1) $display("FAIL b2b_done_valid: got %b required 1", out_valid); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL b2b_done_ready: got %b required 0", in_ready); else passed++;
    checks++; if (out_sum !== es) $display("FAIL b2b_sum: got %0d required %0d", out_sum, es); else passed++;
    checks++; if (out_count !== ec) $display("FAIL b2b_count: got %0d required %0d", out_count, ec); else passed++;
    checks++; if (out_ovf !== 1'b0) $display("FAIL b2b_ovf: got %b required 0", out_ovf); else passed++;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL b2b_after_hs_valid: got %b required 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_after_hs_ready: got %b required 1", in_ready); else passed++;
    checks++; if (hs_cnt !== hs0 + 1) $display("FAIL b2b_hs_count: got %0d required %0d", hs_cnt, hs0 + 1); else passed++;
  endtask

  task automatic test_early_close();
    bit ok;
    logic [ACC_W-1:0] es;
    logic [CNT_W-1:0] ec;
    send(4'd4, 4'd4, 1'b0);
    send(4'd6, 4'd2, 1'b1);
    wait_out(ok);
    checks++; if (!ok) $display("FAIL early_timeout: out_valid=%b required 1", out_valid); else passed++;
    es = exp_q.pop_front(); ec = cnt_q.pop_front();
    checks++; if (out_sum !== es) $display("FAIL early_sum: got %0d required %0d", out_sum, es); else passed++;
    checks++; if (out_count !== ec) $display("FAIL early_count: got %0d required %0d", out_count, ec); else passed++;
    @(posedge clk); #1;
    send(4'd1, 4'd1, 1'b1);
    wait_out(ok);
    checks++; if (!ok) $display("FAIL single_timeout: out_valid=%b required 1", out_valid); else passed++;
    es = exp_q.pop_front(); ec = cnt_q.pop_front();
    checks++; if (out_sum !== es) $display("FAIL single_sum: got %0d required %0d", out_sum, es); else passed++;
    checks++; if (out_count !== ec) $display("FAIL single_count: got %0d required %0d", out_count, ec); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [ACC_W-1:0] es;
    logic [CNT_W-1:0] ec;
    int hs0;
    int acc0;
    out_ready = 1'b0;
    send(4'd5, 4'd4, 1'b0);
    send(4'd5, 4'd4, 1'b0);
    send(4'd4, 4'd5, 1'b1);
    wait_out(ok);
    checks++; if (!ok) $display("FAIL bp_timeout: out_valid=%b required 1", out_valid); else passed++;
    es = exp_q.pop_front(); ec = cnt_q.pop_front();
    hs0 = hs_cnt; acc0 = acc_cnt;
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b required 1", i, out_valid); else passed++;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_hold_ready[%0d]: got %b required 0", i, in_ready); else passed++;
      checks++; if (out_sum !== es) $display("FAIL bp_hold_sum[%0d]: got %0d required %0d", i, out_sum, es); else passed++;
      checks++; if (out_count !== ec) $display("FAIL bp_hold_count[%0d]: got %0d required %0d", i, out_count, ec); else passed++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b required 0", out_valid); else passed++;
    idle(3);
    checks++; if (hs_cnt !== hs0 + 1) $display("FAIL bp_hs_count: got %0d required %0d", hs_cnt, hs0 + 1); else passed++;
    checks++; if (acc_cnt !== acc0) $display("FAIL bp_no_consume: got %0d accepts required %0d", acc_cnt, acc0); else passed++;
  endtask

  task automatic test_input_gaps();
    bit ok;
    logic [ACC_W-1:0] es;
    logic [CNT_W-1:0] ec;
    send(4'd7, 4'd3, 1'b0);
    idle(3);
    send(4'd2, 4'd2, 1'b0);
    idle(1);
    send(4'd1, 4'd5, 1'b0);
    send(4'd0, 4'd0, 1'b0);
    wait_out(ok);
    checks++; if (!ok) $display("FAIL gaps_timeout: out_valid=%b required 1", out_valid); else passed++;
    es = exp_q.pop_front(); ec = cnt_q.pop_front();
    checks++; if (out_sum !== es) $display("FAIL gaps_sum: got %0d required %0d", out_sum, es); else passed++;
    checks++; if (out_count !== ec) $display("FAIL gaps_count: got %0d required %0d", out_count, ec); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_group();
    bit ok;
    bit seen;
    logic [ACC_W-1:0] es;
    logic [CNT_W-1:0] ec;
    send(4'd2, 4'd2, 1'b0);
    send(4'd3, 4'd3, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b required 0", in_ready); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_m = 0; cnt_m = 0;
    checks++; if (out_count !== '0) $display("FAIL midrst_count: got %0d required 0", out_count); else passed++;
    checks++; if (out_sum !== '0) $display("FAIL midrst_sum: got %0d required 0", out_sum); else passed++;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) $display("FAIL midrst_no_output: out_valid seen=%b required 0", seen); else passed++;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(4'd2, 4'd3, 1'b0);
    wait_out(ok);
    checks++; if (!ok) $display("FAIL midrst_timeout: out_valid=%b required 1", out_valid); else passed++;
    es = exp_q.pop_front(); ec = cnt_q.pop_front();
    checks++; if (out_sum !== es) $display("FAIL midrst_next_sum: got %0d required %0d", out_sum, es); else passed++;
    checks++; if (out_count !== ec) $display("FAIL midrst_next_count: got %0d required %0d", out_count, ec); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int raw;
    int guard;
    logic [7:0] es;
    logic eo;
    raw = 15 * 15 * 2;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    es = (raw > 255) ? 8'd255 : 8'(raw);
    eo = (raw > 255);
`else
    es = 8'(raw % 256);
    eo = 1'b0;
`endif
    out_ready = 1'b1;
    in_a = 4'd15; in_b = 4'd15; in_last = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    checks++; if (in_ready8 !== 1'b1) $display("FAIL ovf_in_ready: got %b required 1", in_ready8); else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    guard = 0;
    while (!out_valid8 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (out_valid8 !== 1'b1) $display("FAIL ovf_timeout: out_valid=%b required 1", out_valid8); else passed++;
    checks++; if (out_sum8 !== es) $display("FAIL ovf_sum: got %0d required %0d", out_sum8, es); else passed++;
    checks++; if (out_ovf8 !== eo) $display("FAIL ovf_flag: got %b required %b", out_ovf8, eo); else passed++;
    checks++; if (out_count8 !== 2'd2) $display("FAIL ovf_count: got %0d required 2", out_count8); else passed++;
    @(posedge clk); #1;
    checks++; if (out_ovf8 !== 1'b0) $display("FAIL ovf_clear: got %b required 0", out_ovf8); else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_back_to_back();
    test_early_close();
    test_backpressure();
    test_input_gaps();
    test_reset_mid_group();
    test_overflow();
    checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
